// File: rtl/game_pkg.sv
// Shared definitions for the sprite game blocks: coordinate width, colour
// packing and the bullet scheduler FSM state type.
package game_pkg;

   localparam int COORD_W = 11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      SPAWN  = 2'd2
   } fsm_state_t;

   // RGB565 spread across a 24-bit word as {3'b0,R5,2'b0,G6,3'b0,B5}
   function automatic logic [23:0] rgb565_pack(input logic [4:0] r,
                                               input logic [5:0] g,
                                               input logic [4:0] b);
      return {3'b000, r, 2'b00, g, 3'b000, b};
   endfunction

   localparam logic [23:0] BULLET_COLOR = rgb565_pack(5'd31, 6'd63, 5'd0);

endpackage

// File: rtl/fire_edge_sync.sv
// Brings the asynchronous fire button into the pixel clock domain and
// emits a one-cycle pulse on each synchronised rising edge.
module fire_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/gun_fire_ctrl.sv
// Player gun bullet scheduler: spawns bullets on fire under a frame cooldown,
// moves them left once per frame and renders them as a registered pixel stream.
module gun_fire_ctrl
   import game_pkg::*;
#(
   parameter int N_SLOTS         = 4,
   parameter int SLOT_W          = 2,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int STEP            = 4,
   parameter int X_MIN           = 0,
   parameter int BULLET_W        = 8,
   parameter int BULLET_H        = 4,
   parameter int MUZZLE_DY       = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [COORD_W-1:0]  lcd_xpos,
   input  logic [COORD_W-1:0]  lcd_ypos,
   input  logic [COORD_W-1:0]  gun_x,
   input  logic [COORD_W-1:0]  gun_y,
   input  logic                fire,
   input  logic                hit_valid,
   input  logic [SLOT_W-1:0]   hit_slot,
   output logic [23:0]         bullet_pixel,
   output logic                pixel_valid,
   output logic                shot_fired,
   output logic [N_SLOTS-1:0]  active_mask
);

   localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
   localparam int CW1  = COORD_W + 1;

   fsm_state_t          r_state;
   logic [SLOT_W-1:0]   r_idx;
   logic [N_SLOTS-1:0]  r_active;
   logic [COORD_W-1:0]  r_x [N_SLOTS];
   logic [COORD_W-1:0]  r_y [N_SLOTS];
   logic [CD_W-1:0]     r_cooldown;
   logic                r_fire_pending;
   logic                r_shot_fired;
   logic                r_origin_d;
   logic                r_pixel_valid;
   logic [23:0]         r_bullet_pixel;

   logic                w_fire_edge;
   logic                w_at_origin;
   logic                w_frame_tick;
   logic                w_free_any;
   logic [SLOT_W-1:0]   w_free_idx;
   logic [N_SLOTS-1:0]  w_cover;

   fire_edge_sync u_fire_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (fire),
      .o_pulse (w_fire_edge)
   );

   // Frame start is the first cycle the scan sits at the origin.
   assign w_at_origin  = (lcd_xpos == '0) && (lcd_ypos == '0);
   assign w_frame_tick = w_at_origin & ~r_origin_d;

   always_comb begin
      w_free_any = 1'b0;
      w_free_idx = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (!r_active[i]) begin
            w_free_any = 1'b1;
            w_free_idx = SLOT_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_idx          <= '0;
         r_active       <= '0;
         r_cooldown     <= '0;
         r_fire_pending <= 1'b0;
         r_shot_fired   <= 1'b0;
         r_origin_d     <= 1'b0;
         for (int i = 0; i < N_SLOTS; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
         end
      end else begin
         r_origin_d   <= w_at_origin;
         r_shot_fired <= 1'b0;
         if (w_fire_edge)
            r_fire_pending <= 1'b1;

         case (r_state)
            IDLE: begin
               if (w_frame_tick) begin
                  r_state <= UPDATE;
                  r_idx   <= '0;
                  if (r_cooldown != '0)
                     r_cooldown <= r_cooldown - 1'b1;
               end
            end
            UPDATE: begin
               // Compare before subtracting so x can never wrap past zero.
               if (r_active[r_idx]) begin
                  if (r_x[r_idx] < COORD_W'(X_MIN + STEP))
                     r_active[r_idx] <= 1'b0;
                  else
                     r_x[r_idx] <= r_x[r_idx] - COORD_W'(STEP);
               end
               if (r_idx == SLOT_W'(N_SLOTS - 1))
                  r_state <= SPAWN;
               else
                  r_idx <= r_idx + 1'b1;
            end
            SPAWN: begin
               if (r_fire_pending && (r_cooldown == '0) && w_free_any) begin
                  r_active[w_free_idx] <= 1'b1;
                  r_x[w_free_idx]      <= gun_x - COORD_W'(BULLET_W);
                  r_y[w_free_idx]      <= gun_y + COORD_W'(MUZZLE_DY);
                  r_cooldown           <= CD_W'(COOLDOWN_FRAMES);
                  r_fire_pending       <= 1'b0;
                  r_shot_fired         <= 1'b1;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase

         // Last assignment wins: a kill overrides any same-cycle slot write.
         if (hit_valid)
            r_active[hit_slot] <= 1'b0;
      end
   end

   for (genvar s = 0; s < N_SLOTS; s++) begin : g_cover
      logic [CW1-1:0] w_x_end;
      logic [CW1-1:0] w_y_end;
      assign w_x_end = {1'b0, r_x[s]} + CW1'(BULLET_W);
      assign w_y_end = {1'b0, r_y[s]} + CW1'(BULLET_H);
      assign w_cover[s] = r_active[s]
                        && (lcd_xpos >= r_x[s]) && ({1'b0, lcd_xpos} < w_x_end)
                        && (lcd_ypos >= r_y[s]) && ({1'b0, lcd_ypos} < w_y_end);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pixel_valid  <= 1'b0;
         r_bullet_pixel <= '0;
      end else begin
         r_pixel_valid  <= |w_cover;
         r_bullet_pixel <= (|w_cover) ? BULLET_COLOR : 24'h0;
      end
   end

   assign bullet_pixel = r_bullet_pixel;
   assign pixel_valid  = r_pixel_valid;
   assign shot_fired   = r_shot_fired;
   assign active_mask  = r_active;

endmodule

// File: tb/tb_gun_fire_ctrl.sv
// Directed bench for gun_fire_ctrl with a scoreboard queue of expected results.
module tb_gun_fire_ctrl;

   localparam int N_SLOTS = 4;
   localparam logic [23:0] COLOR = 24'h1F3F00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] lcd_xpos = 11'd1000;
   logic [10:0] lcd_ypos = 11'd500;
   logic [10:0] gun_x = 11'd730;
   logic [10:0] gun_y = 11'd220;
   logic        fire = 1'b0;
   logic        hit_valid = 1'b0;
   logic [1:0]  hit_slot = 2'd0;
   logic [23:0] bullet_pixel;
   logic        pixel_valid;
   logic        shot_fired;
   logic [3:0]  active_mask;

   gun_fire_ctrl #(
      .N_SLOTS(4), .SLOT_W(2), .COOLDOWN_FRAMES(8), .STEP(4), .X_MIN(0),
      .BULLET_W(8), .BULLET_H(4), .MUZZLE_DY(10)
   ) dut (
      .clk(clk), .rst(rst), .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
      .gun_x(gun_x), .gun_y(gun_y), .fire(fire), .hit_valid(hit_valid),
      .hit_slot(hit_slot), .bullet_pixel(bullet_pixel), .pixel_valid(pixel_valid),
      .shot_fired(shot_fired), .active_mask(active_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   shot_cnt = 0;

   always @(negedge clk) if (shot_fired === 1'b1) shot_cnt++;

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_errors++;
         $error("FAIL sb_empty obs=%0h", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.exp) else begin
         n_errors++;
         $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.exp);
      end
   endtask

   task automatic chk_mask(input logic [3:0] exp, input string tag);
      push(tag, {28'h0, exp});
      @(negedge clk);
      pop_check({28'h0, active_mask});
   endtask

   task automatic probe(input int x, input int y, input bit exp_v, input string tag);
      @(posedge clk); #1;
      lcd_xpos = 11'(x);
      lcd_ypos = 11'(y);
      push({tag, "_valid"}, {31'h0, exp_v});
      push({tag, "_pixel"}, exp_v ? {8'h0, COLOR} : 32'h0);
      @(posedge clk);
      @(negedge clk);
      pop_check({31'h0, pixel_valid});
      pop_check({8'h0, bullet_pixel});
      @(posedge clk); #1;
      lcd_xpos = 11'd1000;
      lcd_ypos = 11'd500;
   endtask

   task automatic fire_edge();
      @(posedge clk); #1 fire = 1'b1;
      repeat (4) @(posedge clk);
      #1 fire = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   // One frame: scan parks on the origin long enough for the update burst
   task automatic frame(input int exp_shots, input string tag);
      int s0;
      push(tag, 32'(exp_shots));
      @(posedge clk); #1;
      s0 = shot_cnt;
      lcd_xpos = 11'd0;
      lcd_ypos = 11'd0;
      repeat (N_SLOTS + 4) @(posedge clk);
      #1 lcd_xpos = 11'd1000;
      lcd_ypos = 11'd500;
      repeat (2) @(posedge clk);
      @(negedge clk);
      pop_check(32'(shot_cnt - s0));
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic hit(input logic [1:0] slot);
      @(posedge clk); #1;
      hit_valid = 1'b1;
      hit_slot  = slot;
      @(posedge clk); #1;
      hit_valid = 1'b0;
   endtask

   initial begin
      int s0;
      // Reset state while rst is held
      repeat (3) @(posedge clk);
      push("rst_mask", 32'h0);
      push("rst_valid", 32'h0);
      push("rst_pixel", 32'h0);
      push("rst_shot", 32'h0);
      @(negedge clk);
      pop_check({28'h0, active_mask});
      pop_check({31'h0, pixel_valid});
      pop_check({8'h0, bullet_pixel});
      pop_check({31'h0, shot_fired});
      @(posedge clk); #1 rst = 1'b0;

      // Spawn at frame 1
      fire_edge();
      frame(1, "f1_shot");
      chk_mask(4'b0001, "f1_mask");
      probe(722, 230, 1'b1, "spawn_tl");
      probe(721, 230, 1'b0, "spawn_left");
      probe(730, 230, 1'b0, "spawn_right");
      probe(722, 234, 1'b0, "spawn_below");
      probe(729, 233, 1'b1, "spawn_br");

      // Motion: fire every frame, cooldown blocks spawns until frame 9
      for (int f = 2; f <= 4; f++) begin
         fire_edge();
         frame(0, $sformatf("f%0d_shot", f));
      end
      probe(710, 230, 1'b1, "move_tl");
      probe(709, 230, 1'b0, "move_left");
      probe(710, 229, 1'b0, "move_above");
      for (int f = 5; f <= 17; f++) begin
         fire_edge();
         frame((f == 9 || f == 17) ? 1 : 0, $sformatf("f%0d_shot", f));
      end
      push("cool_total", 32'd3);
      pop_check(32'(shot_cnt));
      chk_mask(4'b0111, "f17_mask");

      // Kill of an inactive slot leaves the pool untouched
      hit(2'd3);
      chk_mask(4'b0111, "hit_idle_mask");

      // Fill the pool, then a pending fire is blocked while full
      fire_edge();
      for (int f = 18; f <= 25; f++) frame((f == 25) ? 1 : 0, $sformatf("f%0d_shot", f));
      chk_mask(4'b1111, "full_mask");
      fire_edge();
      for (int f = 26; f <= 33; f++) frame(0, $sformatf("f%0d_shot", f));
      chk_mask(4'b1111, "full_block_mask");
      hit(2'd2);
      chk_mask(4'b1011, "hit2_mask");
      frame(1, "refill_shot");
      chk_mask(4'b1111, "refill_mask");
      probe(722, 230, 1'b1, "refill_pos");

      // Reset during UPDATE with slots live, cooldown running and a fire pending
      fire_edge();
      @(posedge clk); #1;
      s0 = shot_cnt;
      lcd_xpos = 11'd0;
      lcd_ypos = 11'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      push("midrst_mask", 32'h0);
      push("midrst_valid", 32'h0);
      @(negedge clk);
      pop_check({28'h0, active_mask});
      pop_check({31'h0, pixel_valid});
      repeat (N_SLOTS + 4) @(posedge clk);
      #1 lcd_xpos = 11'd1000;
      lcd_ypos = 11'd500;
      repeat (2) @(posedge clk);
      push("midrst_noshot", 32'h0);
      @(negedge clk);
      pop_check(32'(shot_cnt - s0));
      fire_edge();
      frame(1, "postrst_shot");
      chk_mask(4'b0001, "postrst_mask");

      // Left edge: x=4 steps to 0 and survives one frame
      do_reset();
      gun_x = 11'd12;
      fire_edge();
      frame(1, "edge4_shot");
      probe(4, 230, 1'b1, "edge4_pos");
      probe(3, 230, 1'b0, "edge4_left");
      frame(0, "edge4_f2");
      chk_mask(4'b0001, "edge0_mask");
      probe(0, 230, 1'b1, "edge0_pos");
      probe(8, 230, 1'b0, "edge0_right");
      frame(0, "edge0_f3");
      chk_mask(4'b0000, "edge0_gone");
      probe(2040, 230, 1'b0, "edge_nowrap");

      // Left edge: x=3 is removed on the next update
      do_reset();
      gun_x = 11'd11;
      fire_edge();
      frame(1, "edge3_shot");
      probe(3, 230, 1'b1, "edge3_pos");
      frame(0, "edge3_f2");
      chk_mask(4'b0000, "edge3_gone");
      probe(2043, 230, 1'b0, "edge3_nowrap");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
